// File: rtl/pulse_gen_multi.sv
// pulse_gen_multi
//
// Conditions raw push-button levels into clean single-cycle enables.
// Each channel has its own two-flop synchroniser, an integrating debouncer,
// an edge-selectable one-pulse generator and an optional auto-repeat engine.
// All channels share one clock, one reset and the parameter set.
//
// Ports
//   clk          system clock, every flop updates on the rising edge
//   rst          asynchronous, active-high reset
//   btn_i        raw, asynchronous button levels, one bit per channel
//   rep_en_i     auto-repeat enable, synchronous, common to all channels
//   pulse_o      one-cycle enable per detected edge or repeat, per channel
//   level_o      debounced button level, per channel
//   any_pulse_o  OR of pulse_o, registered in the same cycle as pulse_o
//
// Auto-repeat FSM (per channel, active only when EDGE_MODE == 0)
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | debounced level is idle, nothing pending
//   ST_HOLD   | button held, timing the initial HOLD_CYCLES delay
//   ST_REPEAT | button held, emitting a pulse every REPEAT_CYCLES
//
// With EDGE_MODE != 0 the FSM only tracks IDLE/HOLD and its counter stays 0.

module pulse_gen_multi #(
    parameter int   CHANNELS        = 4,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   HOLD_CYCLES     = 8,
    parameter int   REPEAT_CYCLES   = 4,
    parameter int   EDGE_MODE       = 0,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_i,
    input  logic                rep_en_i,
    output logic [CHANNELS-1:0] pulse_o,
    output logic [CHANNELS-1:0] level_o,
    output logic                any_pulse_o
);

    localparam int DB_W   = $clog2((DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2);
    localparam int RP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RP_W   = $clog2(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYCLES - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYCLES - 1);

    localparam bit REPEAT_ON = (EDGE_MODE == 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    // Next-cycle pulse per channel; registered below into pulse_o and any_pulse_o
    logic [CHANNELS-1:0] pulse_nxt;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic            sync_q1;
        logic            sync_q2;
        logic            level_q;
        logic [DB_W-1:0] db_cnt;
        logic [RP_W-1:0] rep_cnt;
        rep_state_t      state;

        logic differ;
        logic flip;
        logic press;
        logic rel;
        logic edge_hit;
        logic rep_hit;

        assign differ = (sync_q2 != level_q);

        // The level flips on the edge where the synchronised input has
        // disagreed with it for DEBOUNCE_CYCLES consecutive edges.
        assign flip  = differ && (db_cnt == DB_LAST);
        assign press = flip && (level_q == IDLE_LEVEL);
        assign rel   = flip && (level_q != IDLE_LEVEL);

        assign edge_hit = (EDGE_MODE == 0) ? press :
                          (EDGE_MODE == 1) ? rel   : flip;

        // A release on the same edge as a due repeat suppresses the repeat.
        assign rep_hit = REPEAT_ON && rep_en_i && !rel &&
                         (((state == ST_HOLD)   && (rep_cnt == HOLD_LAST)) ||
                          ((state == ST_REPEAT) && (rep_cnt == REP_LAST)));

        assign pulse_nxt[g] = edge_hit | rep_hit;
        assign level_o[g]   = level_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q1 <= IDLE_LEVEL;
                sync_q2 <= IDLE_LEVEL;
                level_q <= IDLE_LEVEL;
                db_cnt  <= '0;
                rep_cnt <= '0;
                state   <= ST_IDLE;
            end else begin
                sync_q1 <= btn_i[g];
                sync_q2 <= sync_q1;

                if (!differ) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    db_cnt  <= '0;
                    level_q <= ~level_q;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end

                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            state   <= ST_HOLD;
                            rep_cnt <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (rel) begin
                            state   <= ST_IDLE;
                            rep_cnt <= '0;
                        end else if (!REPEAT_ON || !rep_en_i) begin
                            // Disabled repeat restarts the full hold delay later
                            rep_cnt <= '0;
                        end else if (rep_cnt == HOLD_LAST) begin
                            state   <= ST_REPEAT;
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (rel) begin
                            state   <= ST_IDLE;
                            rep_cnt <= '0;
                        end else if (!rep_en_i) begin
                            state   <= ST_HOLD;
                            rep_cnt <= '0;
                        end else if (rep_cnt == REP_LAST) begin
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        rep_cnt <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_o     <= '0;
            any_pulse_o <= 1'b0;
        end else begin
            pulse_o     <= pulse_nxt;
            any_pulse_o <= |pulse_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: instance 0 uses the default parameters
// (press pulses, auto-repeat, idle-low buttons); instance 1 pulses on both
// edges with idle-high buttons and is fed the inverted button vector.

module tb_pulse_gen_multi;

    localparam int CH = 4;
    localparam int DC = 4;
    localparam int HC = 8;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] btn = '0;
    logic [CH-1:0] btn_n;
    logic          rep_en = 1'b0;

    logic [CH-1:0] pulse0, level0, pulse1, level1;
    logic          any0, any1;

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cyc   = 0;

    // reference model state, [instance][channel]
    logic          m_s1    [2][CH];
    logic          m_s     [2][CH];
    logic          m_lvl   [2][CH];
    int            m_run   [2][CH];
    bit            m_armed [2][CH];
    int            m_due   [2][CH];
    logic [CH-1:0] exp_pulse [2];
    logic [CH-1:0] exp_level [2];
    logic          exp_any   [2];

    logic [17:0] dut_vec;
    logic [17:0] mdl_vec;

    assign btn_n   = ~btn;
    assign dut_vec = {pulse0, level0, any0, pulse1, level1, any1};
    assign mdl_vec = {exp_pulse[0], exp_level[0], exp_any[0],
                      exp_pulse[1], exp_level[1], exp_any[1]};

    pulse_gen_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC), .EDGE_MODE(0), .IDLE_LEVEL(1'b0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .btn_i(btn), .rep_en_i(rep_en),
        .pulse_o(pulse0), .level_o(level0), .any_pulse_o(any0)
    );

    pulse_gen_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC), .EDGE_MODE(2), .IDLE_LEVEL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .btn_i(btn_n), .rep_en_i(rep_en),
        .pulse_o(pulse1), .level_o(level1), .any_pulse_o(any1)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CH; c++) begin
                m_s1[m][c]    = (m == 1);
                m_s[m][c]     = (m == 1);
                m_lvl[m][c]   = (m == 1);
                m_run[m][c]   = 0;
                m_armed[m][c] = 1'b0;
                m_due[m][c]   = 0;
            end
            exp_pulse[m] = '0;
            exp_level[m] = (m == 1) ? '1 : '0;
            exp_any[m]   = 1'b0;
        end
    endfunction

    // One clock edge of the behavioural model: the level follows the
    // synchronised input once it has disagreed for DC edges in a row; repeats
    // are scheduled as absolute deadlines (press + HC, then every RC).
    function automatic void model_update();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CH; c++) begin
                logic idle, raw, fl, pr, rl, eh, rp;
                idle = (m == 1);
                raw  = (m == 0) ? btn[c] : ~btn[c];
                fl   = 1'b0;
                rp   = 1'b0;
                if (m_s[m][c] != m_lvl[m][c]) begin
                    m_run[m][c] = m_run[m][c] + 1;
                    if (m_run[m][c] == DC) begin
                        fl = 1'b1;
                        m_run[m][c] = 0;
                    end
                end else begin
                    m_run[m][c] = 0;
                end
                pr = fl && (m_lvl[m][c] == idle);
                rl = fl && (m_lvl[m][c] != idle);
                eh = (m == 0) ? pr : fl;
                if (m == 0) begin
                    if (pr) begin
                        m_armed[m][c] = 1'b1;
                        m_due[m][c]   = tb_cyc + HC;
                    end else if (m_armed[m][c]) begin
                        if (rl) m_armed[m][c] = 1'b0;
                        else if (!rep_en) m_due[m][c] = tb_cyc + HC;
                        else if (tb_cyc == m_due[m][c]) begin
                            rp = 1'b1;
                            m_due[m][c] = tb_cyc + RC;
                        end
                    end
                end
                m_s[m][c]       = m_s1[m][c];
                m_s1[m][c]      = raw;
                m_lvl[m][c]     = m_lvl[m][c] ^ fl;
                exp_pulse[m][c] = eh | rp;
                exp_level[m][c] = m_lvl[m][c];
            end
            exp_any[m] = |exp_pulse[m];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        tb_cyc++;
        if (rst) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic settle();
        btn    = '0;
        rep_en = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 18'h0001E) $display("FAIL reset_async got=%h exp=%h", dut_vec, 18'h0001E);
        else n_pass++;
        repeat (3) begin
            tick();
            n_checks++;
            if (dut_vec !== 18'h0001E) $display("FAIL reset_hold got=%h exp=%h", dut_vec, 18'h0001E);
            else n_pass++;
        end
        rst = 1'b0;
        repeat (8) begin
            tick();
            n_checks++;
            if (dut_vec !== 18'h0001E) $display("FAIL reset_release got=%h exp=%h", dut_vec, 18'h0001E);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_press();
        rep_en = 1'b0;
        btn[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL press_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
            if (i == 5) begin
                n_checks++;
                if ({level0, pulse0} !== 8'h00) $display("FAIL press_early level=%b pulse=%b exp=0000/0000", level0, pulse0);
                else n_pass++;
            end
            if (i == 6) begin
                n_checks++;
                if ({level0, pulse0, any0} !== 9'b0001_0001_1) $display("FAIL press_edge level=%b pulse=%b any=%b exp=0001/0001/1", level0, pulse0, any0);
                else n_pass++;
            end
            if (i == 7) begin
                n_checks++;
                if ({level0, pulse0, any0} !== 9'b0001_0000_0) $display("FAIL press_width level=%b pulse=%b any=%b exp=0001/0000/0", level0, pulse0, any0);
                else n_pass++;
            end
        end
        btn[0] = 1'b0;
        repeat (12) begin
            tick();
            n_checks++;
            if (pulse0 !== 4'b0000) $display("FAIL press_release_pulse cyc=%0d got=%b exp=0000", tb_cyc, pulse0);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL press_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        settle();
        btn[1] = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 3) btn[1] = 1'b0;
            n_checks++;
            if (level0[1] !== 1'b0 || pulse0 !== 4'b0000) $display("FAIL glitch cyc=%0d level=%b pulse=%b exp=0/0000", tb_cyc, level0[1], pulse0);
            else n_pass++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL glitch_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    task automatic test_both_edges();
        int c0 = 0;
        int c1 = 0;
        settle();
        btn[2] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 11) btn[2] = 1'b0;
            if (pulse0[2]) c0++;
            if (pulse1[2]) c1++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL both_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (c1 != 2) $display("FAIL both_edges_count got=%0d exp=2", c1);
        else n_pass++;
        n_checks++;
        if (c0 != 1) $display("FAIL press_only_count got=%0d exp=1", c0);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int p = 0;
        int r;
        int late = 0;
        bit found = 1'b0;
        int q[$];
        int exp_off[6] = '{8, 12, 16, 20, 24, 28};
        settle();
        rep_en = 1'b1;
        btn[0] = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL repeat_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
            if (pulse0[0]) begin
                found = 1'b1;
                p = tb_cyc;
            end
        end
        n_checks++;
        if (!found) begin
            $display("FAIL repeat_press_timeout got=none exp=pulse within 20 cycles");
            p = tb_cyc;
        end else n_pass++;
        while (tb_cyc < p + 30) begin
            tick();
            if (pulse0[0]) q.push_back(tb_cyc - p);
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL repeat_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (q.size() != 6) $display("FAIL repeat_count got=%0d exp=6", q.size());
        else begin
            n_pass++;
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (q[k] != exp_off[k]) $display("FAIL repeat_offset idx=%0d got=%0d exp=%0d", k, q[k], exp_off[k]);
                else n_pass++;
            end
        end
        btn[0] = 1'b0;
        r = tb_cyc;
        repeat (16) begin
            tick();
            if (pulse0[0] && tb_cyc > r + DC + 2) late++;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL repeat_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (late != 0) $display("FAIL repeat_after_release got=%0d exp=0", late);
        else n_pass++;
    endtask

    task automatic test_rep_toggle();
        int p = 0;
        bit found = 1'b0;
        int q[$];
        settle();
        rep_en = 1'b1;
        btn[0] = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (pulse0[0]) begin
                found = 1'b1;
                p = tb_cyc;
            end
        end
        n_checks++;
        if (!found) begin
            $display("FAIL toggle_press_timeout got=none exp=pulse within 20 cycles");
            p = tb_cyc;
        end else n_pass++;
        while (tb_cyc < p + 24) begin
            tick();
            if (pulse0[0]) q.push_back(tb_cyc - p);
            if (tb_cyc == p + 10) rep_en = 1'b0;
            if (tb_cyc == p + 14) rep_en = 1'b1;
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL toggle_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (q.size() != 2) $display("FAIL toggle_count got=%0d exp=2", q.size());
        else begin
            n_pass++;
            n_checks++;
            if (q[0] != 8 || q[1] != 22) $display("FAIL toggle_offsets got=%0d,%0d exp=8,22", q[0], q[1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int first = 0;
        settle();
        rep_en = 1'b1;
        btn[0] = 1'b1;
        repeat (20) tick();
        btn[3] = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dut_vec !== 18'h0001E) $display("FAIL reset_mid_async got=%h exp=%h", dut_vec, 18'h0001E);
        else n_pass++;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (pulse0 != 4'b0000 && first == 0) begin
                first = i;
                n_checks++;
                if (pulse0 !== 4'b1001) $display("FAIL reset_mid_pulse got=%b exp=1001", pulse0);
                else n_pass++;
            end
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_mid_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
        end
        n_checks++;
        if (first != DC + 2) $display("FAIL reset_mid_latency got=%0d exp=%0d", first, DC + 2);
        else n_pass++;
    endtask

    task automatic test_random();
        int rem[CH];
        settle();
        for (int c = 0; c < CH; c++) rem[c] = $urandom_range(1, 30);
        for (int n = 0; n < 3000; n++) begin
            tick();
            n_checks++;
            if (dut_vec !== mdl_vec) $display("FAIL random_model cyc=%0d got=%h exp=%h", tb_cyc, dut_vec, mdl_vec);
            else n_pass++;
            for (int c = 0; c < CH; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
                end
            end
            if ($urandom_range(0, 29) == 0) rep_en = ~rep_en;
            if ($urandom_range(0, 799) == 0) begin
                rst = 1'b1;
                model_reset();
                tick();
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_both_edges();
        test_repeat();
        test_rep_toggle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=bench completion", tb_cyc);
        $fatal(1, "bench timeout");
    end

endmodule
